// File: rtl/gcd_engine_param.sv
`default_nettype none
// ============================================================================
// Module   : gcd_engine_param
// Brief    : Self-sequencing WIDTH-bit GCD engine, subtractive or binary
//            (Stein) algorithm, with busy/done handshake and cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module gcd_engine_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] n1,
    input  logic [WIDTH-1:0] n2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero_err,
    output logic [CNT_W-1:0] cycles,
    output logic [2:0]       state_out
);

    localparam int K_W = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_CHECK  = 3'b001,
        S_SUB    = 3'b010,
        S_SHIFT2 = 3'b011,
        S_STEIN  = 3'b100,
        S_DONE   = 3'b101
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             mode_q, mode_d;
    logic             zero_err_q, zero_err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_inc;

    // Saturating increment; the edge that enters DONE is itself counted.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        k_d        = k_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        zero_err_d = zero_err_q;
        cycles_d   = cycles_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = n1;
                    b_d     = n2;
                    mode_d  = mode;
                    k_d     = '0;
                    cnt_d   = '0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                cnt_d = cnt_inc;
                if ((a_q == '0) || (b_q == '0)) begin
                    result_d   = a_q | b_q;
                    zero_err_d = (a_q == '0) && (b_q == '0);
                    cycles_d   = cnt_inc;
                    state_d    = S_DONE;
                end else begin
                    state_d = mode_q ? S_SHIFT2 : S_SUB;
                end
            end
            S_SUB: begin
                cnt_d = cnt_inc;
                if (a_q == b_q) begin
                    result_d   = a_q;
                    zero_err_d = 1'b0;
                    cycles_d   = cnt_inc;
                    state_d    = S_DONE;
                end else if (a_q > b_q) begin
                    a_d = a_q - b_q;
                end else begin
                    b_d = b_q - a_q;
                end
            end
            S_SHIFT2: begin
                cnt_d = cnt_inc;
                if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + K_W'(1);
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else begin
                    state_d = S_STEIN;
                end
            end
            S_STEIN: begin
                // a stays odd here, so swapping on a>b keeps the invariant.
                cnt_d = cnt_inc;
                if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q == b_q) begin
                    result_d   = a_q << k_q;
                    zero_err_d = 1'b0;
                    cycles_d   = cnt_inc;
                    state_d    = S_DONE;
                end else if (a_q > b_q) begin
                    a_d = b_q;
                    b_d = a_q - b_q;
                end else begin
                    b_d = b_q - a_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_CHECK) || (state_d == S_SUB) ||
                 (state_d == S_SHIFT2) || (state_d == S_STEIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            k_q        <= '0;
            mode_q     <= 1'b0;
            cnt_q      <= '0;
            result_q   <= '0;
            zero_err_q <= 1'b0;
            cycles_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            k_q        <= k_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            zero_err_q <= zero_err_d;
            cycles_q   <= cycles_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign zero_err  = zero_err_q;
    assign cycles    = cycles_q;
    assign state_out = state_q;

endmodule
`default_nettype wire
